// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared declarations for the cache memory-side controller:
//   - NUM_PORTS              : number of cache miss ports served by the controller
//   - cache_mem_ctrl_state_t : controller FSM state encoding
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } cache_mem_ctrl_state_t;

endpackage : cache_pkg

// File: rtl/cache_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cache_rr_arbiter
// Two-way round-robin arbiter. When both ports are pending, the port that was
// not granted last wins; a single pending port always wins. Purely
// combinational; the caller owns the last-grant register.
// Ports:
//   pending_i     in  NUM_PORTS  request vector
//   last_grant_i  in  1          port granted by the previous operation
//   grant_valid_o out 1          at least one port is pending
//   grant_o       out 1          index of the winning port
// -----------------------------------------------------------------------------
module cache_rr_arbiter
    import cache_pkg::*;
(
    input  logic [NUM_PORTS-1:0] pending_i,
    input  logic                 last_grant_i,
    output logic                 grant_valid_o,
    output logic                 grant_o
);

    // Grant decode from the pending vector and the last winner
    always_comb begin
        grant_valid_o = |pending_i;
        case (pending_i)
            2'b11:   grant_o = ~last_grant_i;
            2'b10:   grant_o = 1'b1;
            2'b01:   grant_o = 1'b0;
            default: grant_o = 1'b0;
        endcase
    end

endmodule : cache_rr_arbiter

// File: rtl/cache_mem_ctrl.sv
// -----------------------------------------------------------------------------
// cache_mem_ctrl
// Memory-side controller between two cache miss ports and one word-wide RAM.
// Read misses are expanded into BLOCK_SIZE single-word RAM reads (ascending
// from the block base) and the assembled block is returned with a one-cycle
// ram_valid pulse. Word writes become one RAM write, acknowledged by a
// one-cycle write_done pulse.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   prop_address/read_en/write_en/write_data  per-port requests (sampled in IDLE)
//   ram_valid, ram_data            per-port block return (ram_data held)
//   write_done                     per-port write completion pulse
//   busy                           controller not in IDLE
//   mem_req/mem_we/mem_addr/mem_wdata  RAM request, held until mem_ack
//   mem_ack, mem_rdata             RAM accept / read data (same cycle)
// -----------------------------------------------------------------------------
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic [NUM_PORTS-1:0][RAM_ADDRESS_BITS-1:0]          prop_address,
    input  logic [NUM_PORTS-1:0]                                prop_read_en,
    input  logic [NUM_PORTS-1:0]                                prop_write_en,
    input  logic [NUM_PORTS-1:0][DATA_BITS-1:0]                 prop_write_data,
    output logic [NUM_PORTS-1:0]                                ram_valid,
    output logic [NUM_PORTS-1:0][(2**BLOCK_BITS)-1:0][DATA_BITS-1:0] ram_data,
    output logic [NUM_PORTS-1:0]                                write_done,
    output logic                                                busy,
    output logic                                                mem_req,
    output logic                                                mem_we,
    output logic [RAM_ADDRESS_BITS-1:0]                         mem_addr,
    output logic [DATA_BITS-1:0]                                mem_wdata,
    input  logic                                                mem_ack,
    input  logic [DATA_BITS-1:0]                                mem_rdata
);

    localparam int BLOCK_SIZE = 2**BLOCK_BITS;

    typedef logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] block_t;

    cache_mem_ctrl_state_t       state_q, state_d;
    logic [BLOCK_BITS-1:0]       k_q, k_d;
    logic                        last_grant_q, last_grant_d;
    logic                        gnt_q, gnt_d;
    logic [RAM_ADDRESS_BITS-1:0] addr_q, addr_d;
    logic                        wr_q, wr_d;
    block_t                      buf_q, buf_d;
    logic [NUM_PORTS-1:0]        ram_valid_q, ram_valid_d;
    logic [NUM_PORTS-1:0]        write_done_q, write_done_d;
    block_t [NUM_PORTS-1:0]      ram_data_q, ram_data_d;
    logic [RAM_ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0]        mem_wdata_q, mem_wdata_d;

    logic [NUM_PORTS-1:0]        pending_s;
    logic                        grant_valid_s;
    logic                        grant_s;

    assign pending_s = prop_read_en | prop_write_en;

    cache_rr_arbiter u_arb (
        .pending_i     (pending_s),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid_s),
        .grant_o       (grant_s)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        buf_d        = buf_q;
        ram_valid_d  = '0;
        write_done_d = '0;
        ram_data_d   = ram_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    gnt_d       = grant_s;
                    addr_d      = prop_address[grant_s];
                    wr_d        = prop_write_en[grant_s];
                    mem_wdata_d = prop_write_data[grant_s];
                    k_d         = '0;
                    // Write wins over read when a port asserts both
                    if (prop_write_en[grant_s]) begin
                        state_d    = WRITE;
                        mem_addr_d = prop_address[grant_s];
                    end else begin
                        state_d    = READ;
                        mem_addr_d = {prop_address[grant_s][RAM_ADDRESS_BITS-1:BLOCK_BITS],
                                      {BLOCK_BITS{1'b0}}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                // Pulse registers are set on the way into DONE so they are
                // high exactly during the DONE cycle
                if (mem_ack) begin
                    write_done_d[gnt_q] = 1'b1;
                    state_d             = DONE;
                end else begin
                    state_d = WRITE;
                end
            end

            READ: begin
                if (mem_ack) begin
                    buf_d[k_q] = mem_rdata;
                    k_d        = k_q + {{(BLOCK_BITS-1){1'b0}}, 1'b1};
                    mem_addr_d = {addr_q[RAM_ADDRESS_BITS-1:BLOCK_BITS], k_d};
                    if (k_q == BLOCK_BITS'(BLOCK_SIZE-1)) begin
                        ram_valid_d[gnt_q] = 1'b1;
                        ram_data_d[gnt_q]  = buf_d;
                        state_d            = DONE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = READ;
                end
            end

            DONE: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            buf_q        <= '0;
            ram_valid_q  <= '0;
            write_done_q <= '0;
            ram_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            buf_q        <= buf_d;
            ram_valid_q  <= ram_valid_d;
            write_done_q <= write_done_d;
            ram_data_q   <= ram_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // mem_req/mem_we/busy decode straight from state so a reset drops them at once
    assign busy       = (state_q != IDLE);
    assign mem_req    = (state_q == WRITE) || (state_q == READ);
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ram_valid  = ram_valid_q;
    assign write_done = write_done_q;
    assign ram_data   = ram_data_q;

endmodule : cache_mem_ctrl

// File: tb/tb_cache_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_ctrl
// Self-checking bench for cache_mem_ctrl. A RAM responder returns data equal
// to the word address with a programmable number of wait cycles. Expected RAM
// transactions and per-port responses are queued when a request is driven and
// compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_cache_mem_ctrl;
    import cache_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BB = 2;
    localparam int BS = 4;

    typedef logic [BS-1:0][DW-1:0] blk_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [1:0][AW-1:0]   prop_address;
    logic [1:0]           prop_read_en;
    logic [1:0]           prop_write_en;
    logic [1:0][DW-1:0]   prop_write_data;
    logic [1:0]           ram_valid;
    logic [1:0][BS-1:0][DW-1:0] ram_data;
    logic [1:0]           write_done;
    logic                 busy;
    logic                 mem_req;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_ack;
    logic [DW-1:0]        mem_rdata;

    cache_mem_ctrl #(
        .RAM_ADDRESS_BITS (AW),
        .DATA_BITS        (DW),
        .BLOCK_BITS       (BB)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .prop_address    (prop_address),
        .prop_read_en    (prop_read_en),
        .prop_write_en   (prop_write_en),
        .prop_write_data (prop_write_data),
        .ram_valid       (ram_valid),
        .ram_data        (ram_data),
        .write_done      (write_done),
        .busy            (busy),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM word at address A holds A
    assign mem_rdata = DW'(mem_addr);

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } memtx_t;

    typedef struct {
        int   port;
        bit   wr;
        blk_t blk;
    } rsp_t;

    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        bit            force_ack;
        int            exp_cyc;
    } vec_t;

    memtx_t exp_mem_q[$];
    rsp_t   exp_rsp_q[$];
    blk_t   model_data[2];
    vec_t   vecs[6];

    int total = 0;
    int bad   = 0;
    bit sb_on = 1'b0;
    bit ack_force = 1'b0;
    int ack_wait = 0;
    int wcnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_op(input int p, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        memtx_t m;
        rsp_t   r;
        logic [AW-1:0] base;
        r.port = p;
        r.wr   = wr;
        r.blk  = '0;
        if (wr) begin
            m.we = 1'b1; m.addr = addr; m.wdata = wdata;
            exp_mem_q.push_back(m);
        end else begin
            base = {addr[AW-1:BB], 2'b00};
            for (int i = 0; i < BS; i++) begin
                m.we = 1'b0; m.addr = base + AW'(i); m.wdata = '0;
                exp_mem_q.push_back(m);
                r.blk[i] = DW'(base + AW'(i));
            end
        end
        exp_rsp_q.push_back(r);
    endtask

    // RAM responder: acks after ack_wait idle cycles and checks each accepted transaction
    always @(negedge clk) begin
        memtx_t e;
        if (!reset_n) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_req) begin
            if (ack_force || wcnt >= ack_wait) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (sb_on) begin
                    if (exp_mem_q.size() == 0) begin
                        chk("unexpected_mem_tx", {mem_we, mem_addr}, '0);
                    end else begin
                        e = exp_mem_q.pop_front();
                        chk("mem_we", mem_we, e.we);
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = ack_force;
            wcnt    = 0;
        end
    end

    // Response monitor: pops the expected response on every pulse
    always @(negedge clk) begin
        rsp_t r;
        if (sb_on && reset_n) begin
            for (int p = 0; p < 2; p++) begin
                if (ram_valid[p] || write_done[p]) begin
                    if (exp_rsp_q.size() == 0) begin
                        chk("unexpected_pulse", {ram_valid, write_done}, '0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        chk("rsp_port", p, r.port);
                        chk("rsp_kind", {write_done[p], ram_valid[p]}, {r.wr, ~r.wr});
                        if (!r.wr) model_data[p] = r.blk;
                        chk("ram_data_own", ram_data[p], model_data[p]);
                        chk("ram_data_other", ram_data[1-p], model_data[1-p]);
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int cnt;
        bit seen;
        ack_force = v.force_ack;
        ack_wait  = v.waits;
        push_op(v.port, v.wr, v.addr, v.wdata);
        prop_address[v.port]    = v.addr;
        prop_write_data[v.port] = v.wdata;
        if (v.wr) prop_write_en[v.port] = 1'b1;
        else      prop_read_en[v.port]  = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            seen = v.wr ? write_done[v.port] : ram_valid[v.port];
        end
        prop_read_en[v.port]  = 1'b0;
        prop_write_en[v.port] = 1'b0;
        chk("latency", cnt, v.exp_cyc);
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        ack_force = 1'b0;
    endtask

    // Both ports hold a read until they have collected r0 / r1 blocks
    task automatic run_pair(input int r0, input int r1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int rem[2];
        int cnt;
        rem[0] = r0;
        rem[1] = r1;
        prop_address[0] = a0;
        prop_address[1] = a1;
        prop_read_en[0] = (r0 > 0);
        prop_read_en[1] = (r1 > 0);
        cnt = 0;
        while ((rem[0] > 0 || rem[1] > 0) && cnt < 500) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            for (int p = 0; p < 2; p++) begin
                if (ram_valid[p]) begin
                    rem[p]--;
                    if (rem[p] <= 0) prop_read_en[p] = 1'b0;
                end
            end
        end
        prop_read_en = 2'b00;
        chk("pair_in_time", (cnt < 500), 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{port: 0, wr: 1'b0, addr: 10'h2A3, wdata: 32'h0, waits: 0, force_ack: 1'b1, exp_cyc: 5};
        vecs[1] = '{port: 1, wr: 1'b0, addr: 10'h155, wdata: 32'h0, waits: 1, force_ack: 1'b0, exp_cyc: 9};
        vecs[2] = '{port: 1, wr: 1'b1, addr: 10'h010, wdata: 32'hDEADBEEF, waits: 3, force_ack: 1'b0, exp_cyc: 5};
        vecs[3] = '{port: 0, wr: 1'b1, addr: 10'h3FF, wdata: 32'h12345678, waits: 0, force_ack: 1'b0, exp_cyc: 2};
        vecs[4] = '{port: 0, wr: 1'b0, addr: 10'h3FC, wdata: 32'h0, waits: 2, force_ack: 1'b0, exp_cyc: 13};
        vecs[5] = '{port: 1, wr: 1'b0, addr: 10'h000, wdata: 32'h0, waits: 0, force_ack: 1'b1, exp_cyc: 5};

        model_data[0]   = '0;
        model_data[1]   = '0;
        prop_address    = '0;
        prop_read_en    = '0;
        prop_write_en   = '0;
        prop_write_data = '0;
        mem_ack         = 1'b0;
        reset_n         = 1'b1;
        #1 reset_n      = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_ram_valid", ram_valid, '0);
        chk("rst_write_done", write_done, '0);
        chk("rst_ram_data", ram_data, '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        sb_on   = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both ports read and hold: grants alternate 0,1,0,1
        push_op(0, 1'b0, 10'h2A3, '0);
        push_op(1, 1'b0, 10'h155, '0);
        push_op(0, 1'b0, 10'h2A3, '0);
        push_op(1, 1'b0, 10'h155, '0);
        ack_force = 1'b1;
        run_pair(2, 2, 10'h2A3, 10'h155);
        ack_force = 1'b0;

        // Port 0 asserts write and read together: write first, then read
        push_op(0, 1'b1, 10'h0C5, 32'hA5A50F0F);
        push_op(0, 1'b0, 10'h0C5, '0);
        ack_wait = 1;
        prop_address[0]    = 10'h0C5;
        prop_write_data[0] = 32'hA5A50F0F;
        prop_write_en[0]   = 1'b1;
        prop_read_en[0]    = 1'b1;
        begin
            int cnt;
            cnt = 0;
            while ((prop_write_en[0] || prop_read_en[0]) && cnt < 300) begin
                @(posedge clk);
                @(negedge clk);
                cnt++;
                if (write_done[0]) prop_write_en[0] = 1'b0;
                if (ram_valid[0]) begin
                    chk("wr_before_rd", prop_write_en[0], 1'b0);
                    prop_read_en[0] = 1'b0;
                end
            end
            chk("wr_rd_in_time", (cnt < 300), 1'b1);
        end
        prop_write_en[0] = 1'b0;
        prop_read_en[0]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("port1_data_kept", ram_data[1], model_data[1]);
        chk("sb_drained", exp_mem_q.size() + exp_rsp_q.size(), 0);

        // Reset while READ is on word 2
        sb_on = 1'b0;
        ack_force = 1'b1;
        prop_address[0] = 10'h2A3;
        prop_read_en[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midread_addr", mem_addr, 10'h2A2);
        chk("midread_req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mem_addr", mem_addr, '0);
        chk("midrst_ram_data", ram_data, '0);
        prop_read_en = 2'b00;
        ack_force    = 1'b0;
        exp_mem_q.delete();
        exp_rsp_q.delete();
        model_data[0] = '0;
        model_data[1] = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        sb_on   = 1'b1;
        @(negedge clk);

        // After reset port 0 wins first and the block restarts at word 0
        push_op(0, 1'b0, 10'h2A3, '0);
        push_op(1, 1'b0, 10'h155, '0);
        run_pair(1, 1, 10'h2A3, 10'h155);
        chk("sb_drained_end", exp_mem_q.size() + exp_rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cache_mem_ctrl
